// File: rtl/tx_path_arbiter_pkg.sv
// Types and defaults shared by the UART TX path arbiter and its watchdog.
package tx_path_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_TX
    } tx_arb_state_t;

    typedef enum logic {
        SRC_DATA = 1'b0,
        SRC_CTRL = 1'b1
    } tx_src_t;

    localparam int CTRL_BURST_MAX_DEF = 4;
    localparam int TX_TIMEOUT_DEF     = 16384;
    localparam int BURST_W            = 4;

    // Saturating increment of the control burst counter.
    function automatic logic [BURST_W-1:0] burst_next(
        input logic [BURST_W-1:0] cur,
        input logic [BURST_W-1:0] max
    );
        return (cur >= max) ? max : cur + 4'd1;
    endfunction

endpackage

// File: rtl/tx_watchdog_counter.sv
// Cycle counter that flags when a transmit frame has waited too long.
module tx_watchdog_counter #(
    parameter int TX_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic term_o
);

    localparam int W = $clog2(TX_TIMEOUT);
    localparam logic [W-1:0] TERM = W'(TX_TIMEOUT - 1);

    logic [W-1:0] r_cnt;
    logic         w_at_term;

    assign w_at_term = (r_cnt == TERM);
    assign term_o    = enable_i && w_at_term;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i && !w_at_term) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tx_path_arbiter.sv
// Shares the UART transmitter between control packets and TX FIFO data,
// with bounded control bursts, config-time data lockout and a watchdog.
module tx_path_arbiter
    import tx_path_arbiter_pkg::*;
#(
    parameter int CTRL_BURST_MAX = CTRL_BURST_MAX_DEF,
    parameter int TX_TIMEOUT     = TX_TIMEOUT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ctrl_req_i,
    input  logic [7:0] ctrl_data_i,
    output logic       ctrl_grant_o,
    output logic       ctrl_done_o,
    input  logic       cfg_lock_i,
    input  logic       tx_fifo_empty_i,
    input  logic [7:0] tx_fifo_data_i,
    output logic       tx_fifo_read_o,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_done_i,
    output logic       tx_busy_o,
    output logic       tx_src_o,
    output logic       tx_timeout_o
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CTRL_BURST_MAX);

    tx_arb_state_t      r_state;
    logic [BURST_W-1:0] r_burst;
    logic [7:0]         r_tx_data;
    tx_src_t            r_tx_src;
    logic               r_tx_start;
    logic               r_busy;
    logic               r_ctrl_done;
    logic               r_timeout;

    logic w_data_ok;
    logic w_idle;
    logic w_force_data;
    logic w_ctrl_win;
    logic w_data_win;
    logic w_wd_clear;
    logic w_wd_en;
    logic w_wd_term;

    // Grants are combinational, so they are masked while reset is held.
    assign w_data_ok    = !tx_fifo_empty_i && !cfg_lock_i;
    assign w_idle       = (r_state == IDLE) && rst_n_i;
    assign w_force_data = w_data_ok && (r_burst == BURST_MAX);
    assign w_ctrl_win   = w_idle && ctrl_req_i && !w_force_data;
    assign w_data_win   = w_idle && !w_ctrl_win && w_data_ok;

    assign w_wd_clear = (r_state == START);
    assign w_wd_en    = (r_state == WAIT_TX);

    assign ctrl_grant_o   = w_ctrl_win;
    assign tx_fifo_read_o = w_data_win;
    assign ctrl_done_o    = r_ctrl_done;
    assign tx_start_o     = r_tx_start;
    assign tx_data_o      = r_tx_data;
    assign tx_busy_o      = r_busy;
    assign tx_src_o       = (r_tx_src == SRC_CTRL);
    assign tx_timeout_o   = r_timeout;

    tx_watchdog_counter #(
        .TX_TIMEOUT(TX_TIMEOUT)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (w_wd_clear),
        .enable_i(w_wd_en),
        .term_o  (w_wd_term)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_burst     <= '0;
            r_tx_data   <= 8'h00;
            r_tx_src    <= SRC_DATA;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_ctrl_done <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_tx_start  <= 1'b0;
            r_ctrl_done <= 1'b0;
            r_timeout   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_ctrl_win) begin
                        r_tx_data  <= ctrl_data_i;
                        r_tx_src   <= SRC_CTRL;
                        r_burst    <= burst_next(r_burst, BURST_MAX);
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end else if (w_data_win) begin
                        r_tx_data  <= tx_fifo_data_i;
                        r_tx_src   <= SRC_DATA;
                        r_burst    <= '0;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_state <= WAIT_TX;
                end
                WAIT_TX: begin
                    // Done on the terminal cycle takes precedence.
                    if (tx_done_i) begin
                        r_ctrl_done <= (r_tx_src == SRC_CTRL);
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_wd_term) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_path_arbiter.sv
// Scoreboard bench for tx_path_arbiter with a simple transmitter model.
module tb_tx_path_arbiter;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
    } frame_t;

    logic       clk;
    logic       rst_n_i;
    logic       ctrl_req_i;
    logic [7:0] ctrl_data_i;
    logic       ctrl_grant_o;
    logic       ctrl_done_o;
    logic       cfg_lock_i;
    logic       tx_fifo_empty_i;
    logic [7:0] tx_fifo_data_i;
    logic       tx_fifo_read_o;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic       tx_done_i;
    logic       tx_busy_o;
    logic       tx_src_o;
    logic       tx_timeout_o;

    frame_t     exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] ctrl_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tx_delay = 4;
    int tx_wait  = 0;
    int n_start  = 0;
    int n_cdone  = 0;
    int n_tmo    = 0;
    int n_pop    = 0;
    int n_cgrant = 0;
    int start_cyc  = -1;
    int cstart_cyc = -1;
    int cdone_cyc  = -1;
    int tmo_cyc    = -1;

    tx_path_arbiter #(
        .CTRL_BURST_MAX(4),
        .TX_TIMEOUT    (16)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .ctrl_req_i     (ctrl_req_i),
        .ctrl_data_i    (ctrl_data_i),
        .ctrl_grant_o   (ctrl_grant_o),
        .ctrl_done_o    (ctrl_done_o),
        .cfg_lock_i     (cfg_lock_i),
        .tx_fifo_empty_i(tx_fifo_empty_i),
        .tx_fifo_data_i (tx_fifo_data_i),
        .tx_fifo_read_o (tx_fifo_read_o),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .tx_done_i      (tx_done_i),
        .tx_busy_o      (tx_busy_o),
        .tx_src_o       (tx_src_o),
        .tx_timeout_o   (tx_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void expect_frame(input logic s, input logic [7:0] d);
        frame_t f;
        f.src  = s;
        f.data = d;
        exp_q.push_back(f);
    endfunction

    // One clock: sample registered outputs, model the transmitter, drive sources.
    task automatic step();
        frame_t f;
        logic [7:0] gd;
        @(negedge clk);
        cyc++;
        if (tx_start_o) begin
            n_start++;
            start_cyc = cyc;
            if (tx_src_o) cstart_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL start_unexpected: got src=%0b data=%02h, required no frame",
                         tx_src_o, tx_data_o);
            end else begin
                f = exp_q.pop_front();
                if (tx_src_o !== f.src || tx_data_o !== f.data) begin
                    n_fail++;
                    $display("FAIL start_frame: got src=%0b data=%02h, required src=%0b data=%02h",
                             tx_src_o, tx_data_o, f.src, f.data);
                end
            end
        end
        if (ctrl_done_o) begin
            n_cdone++;
            cdone_cyc = cyc;
        end
        if (tx_timeout_o) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
        tx_done_i = 1'b0;
        if (tx_start_o) begin
            tx_wait = tx_delay;
        end else if (tx_wait > 0) begin
            tx_wait--;
            if (tx_wait == 0) tx_done_i = 1'b1;
        end
        tx_fifo_empty_i = (fifo_q.size() == 0);
        tx_fifo_data_i  = tx_fifo_empty_i ? 8'h00 : fifo_q[0];
        ctrl_req_i      = (ctrl_q.size() != 0);
        ctrl_data_i     = ctrl_req_i ? ctrl_q[0] : 8'h00;
        #1;
        if (ctrl_grant_o || tx_fifo_read_o) begin
            gd = ctrl_grant_o ? ctrl_data_i : tx_fifo_data_i;
            n_checks++;
            if (exp_q.size() == 0 || (ctrl_grant_o && tx_fifo_read_o)) begin
                n_fail++;
                $display("FAIL grant_unexpected: got grant=%0b read=%0b, required none",
                         ctrl_grant_o, tx_fifo_read_o);
            end else if (exp_q[0].src !== ctrl_grant_o || exp_q[0].data !== gd) begin
                n_fail++;
                $display("FAIL grant_order: got src=%0b data=%02h, required src=%0b data=%02h",
                         ctrl_grant_o, gd, exp_q[0].src, exp_q[0].data);
            end
            if (ctrl_grant_o && ctrl_q.size() != 0) begin
                void'(ctrl_q.pop_front());
                n_cgrant++;
            end
            if (tx_fifo_read_o && fifo_q.size() != 0) begin
                void'(fifo_q.pop_front());
                n_pop++;
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (!(exp_q.size() == 0 && ctrl_q.size() == 0 &&
                 fifo_q.size() == 0 && !tx_busy_o) && i < budget) begin
            step();
            i++;
        end
        n_checks++;
        if (i >= budget) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d frames pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
            ctrl_q.delete();
            fifo_q.delete();
        end
        step();
        step();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %02h, required 00", tx_data_o);
        end
        n_checks++;
        if ({tx_start_o, tx_busy_o, tx_src_o, ctrl_done_o, tx_timeout_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got %05b, required 00000",
                     {tx_start_o, tx_busy_o, tx_src_o, ctrl_done_o, tx_timeout_o});
        end
        ctrl_req_i      = 1'b1;
        tx_fifo_empty_i = 1'b0;
        #1;
        n_checks++;
        if ({ctrl_grant_o, tx_fifo_read_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_grant: got %02b, required 00",
                     {ctrl_grant_o, tx_fifo_read_o});
        end
        ctrl_req_i      = 1'b0;
        tx_fifo_empty_i = 1'b1;
        rst_n_i         = 1'b1;
        step();
        step();
    endtask

    task automatic test_data_only();
        int p0, s0, c0;
        p0 = n_pop;
        s0 = n_start;
        c0 = n_cdone;
        tx_delay = 4;
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C);
        expect_frame(1'b0, 8'hA5);
        expect_frame(1'b0, 8'h3C);
        drain("data_only", 100);
        n_checks++;
        if (n_pop - p0 != 2 || n_start - s0 != 2) begin
            n_fail++;
            $display("FAIL data_counts: got pops=%0d starts=%0d, required 2 and 2",
                     n_pop - p0, n_start - s0);
        end
        n_checks++;
        if (n_cdone != c0) begin
            n_fail++;
            $display("FAIL data_no_done: got %0d ctrl_done, required 0", n_cdone - c0);
        end
        n_checks++;
        if (tx_data_o !== 8'h3C || tx_src_o !== 1'b0) begin
            n_fail++;
            $display("FAIL data_hold: got data=%02h src=%0b, required 3c and 0",
                     tx_data_o, tx_src_o);
        end
    endtask

    task automatic test_ctrl_priority();
        int c0;
        c0 = n_cdone;
        tx_delay = 4;
        ctrl_q.push_back(8'hFF);
        fifo_q.push_back(8'h11);
        expect_frame(1'b1, 8'hFF);
        expect_frame(1'b0, 8'h11);
        drain("ctrl_prio", 100);
        n_checks++;
        if (n_cdone - c0 != 1) begin
            n_fail++;
            $display("FAIL prio_done_count: got %0d, required 1", n_cdone - c0);
        end
        n_checks++;
        if (cdone_cyc - cstart_cyc != 5) begin
            n_fail++;
            $display("FAIL prio_done_timing: got %0d cycles after start, required 5",
                     cdone_cyc - cstart_cyc);
        end
    endtask

    task automatic test_burst();
        int p0, g0;
        p0 = n_pop;
        g0 = n_cgrant;
        tx_delay = 1;
        for (int i = 0; i < 8; i++) ctrl_q.push_back(8'hC0 + 8'(i));
        fifo_q.push_back(8'hD0);
        fifo_q.push_back(8'hD1);
        for (int i = 0; i < 4; i++) expect_frame(1'b1, 8'hC0 + 8'(i));
        expect_frame(1'b0, 8'hD0);
        for (int i = 4; i < 8; i++) expect_frame(1'b1, 8'hC0 + 8'(i));
        expect_frame(1'b0, 8'hD1);
        drain("burst", 200);
        n_checks++;
        if (n_pop - p0 != 2 || n_cgrant - g0 != 8) begin
            n_fail++;
            $display("FAIL burst_counts: got pops=%0d grants=%0d, required 2 and 8",
                     n_pop - p0, n_cgrant - g0);
        end
    endtask

    task automatic test_cfg_lock();
        int p0, g0, i;
        p0 = n_pop;
        g0 = n_cgrant;
        tx_delay   = 2;
        cfg_lock_i = 1'b1;
        fifo_q.push_back(8'hE0);
        for (int k = 0; k < 7; k++) ctrl_q.push_back(8'h60 + 8'(k));
        for (int k = 0; k < 6; k++) expect_frame(1'b1, 8'h60 + 8'(k));
        expect_frame(1'b0, 8'hE0);
        expect_frame(1'b1, 8'h66);
        i = 0;
        while (n_cgrant - g0 < 6 && i < 200) begin
            step();
            i++;
        end
        step();
        n_checks++;
        if (n_cgrant - g0 != 6 || n_pop != p0) begin
            n_fail++;
            $display("FAIL lock_phase: got grants=%0d pops=%0d, required 6 and 0",
                     n_cgrant - g0, n_pop - p0);
        end
        cfg_lock_i = 1'b0;
        drain("cfg_lock", 100);
        n_checks++;
        if (n_pop - p0 != 1 || n_cgrant - g0 != 7) begin
            n_fail++;
            $display("FAIL lock_release: got pops=%0d grants=%0d, required 1 and 7",
                     n_pop - p0, n_cgrant - g0);
        end
    endtask

    task automatic test_watchdog();
        int c0, t0, i;
        c0 = n_cdone;
        t0 = n_tmo;
        tx_delay = 0;
        tmo_cyc  = -1;
        ctrl_q.push_back(8'h5A);
        expect_frame(1'b1, 8'h5A);
        i = 0;
        while (tmo_cyc < 0 && i < 80) begin
            step();
            i++;
        end
        n_checks++;
        if (tmo_cyc - cstart_cyc != 17) begin
            n_fail++;
            $display("FAIL wd_timing: got timeout %0d cycles after start, required 17",
                     tmo_cyc - cstart_cyc);
        end
        n_checks++;
        if (tx_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_idle: got busy=%0b, required 0", tx_busy_o);
        end
        step();
        step();
        n_checks++;
        if (n_cdone != c0 || n_tmo - t0 != 1) begin
            n_fail++;
            $display("FAIL wd_pulses: got done=%0d timeout=%0d, required 0 and 1",
                     n_cdone - c0, n_tmo - t0);
        end
        tx_delay = 16;
        c0 = n_cdone;
        t0 = n_tmo;
        ctrl_q.push_back(8'h5B);
        expect_frame(1'b1, 8'h5B);
        drain("wd_late_done", 80);
        n_checks++;
        if (n_cdone - c0 != 1 || n_tmo != t0) begin
            n_fail++;
            $display("FAIL wd_late_done: got done=%0d timeout=%0d, required 1 and 0",
                     n_cdone - c0, n_tmo - t0);
        end
        n_checks++;
        if (cdone_cyc - cstart_cyc != 17) begin
            n_fail++;
            $display("FAIL wd_done_timing: got %0d cycles after start, required 17",
                     cdone_cyc - cstart_cyc);
        end
    endtask

    task automatic test_async_reset();
        int c0, t0, p0, i;
        tx_delay = 0;
        ctrl_q.push_back(8'h77);
        expect_frame(1'b1, 8'h77);
        i = 0;
        while (!(tx_busy_o && !tx_start_o) && i < 20) begin
            step();
            i++;
        end
        step();
        step();
        @(posedge clk);
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (tx_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_data: got %02h, required 00", tx_data_o);
        end
        n_checks++;
        if ({tx_start_o, tx_busy_o, tx_src_o, ctrl_grant_o,
             ctrl_done_o, tx_fifo_read_o, tx_timeout_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL arst_outputs: got %07b, required 0000000",
                     {tx_start_o, tx_busy_o, tx_src_o, ctrl_grant_o,
                      ctrl_done_o, tx_fifo_read_o, tx_timeout_o});
        end
        tx_wait = 0;
        c0 = n_cdone;
        t0 = n_tmo;
        step();
        step();
        fifo_q.push_back(8'h9C);
        expect_frame(1'b0, 8'h9C);
        tx_fifo_empty_i = 1'b0;
        tx_fifo_data_i  = 8'h9C;
        #1;
        n_checks++;
        if (tx_fifo_read_o !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_held_read: got %0b, required 0", tx_fifo_read_o);
        end
        @(posedge clk);
        #1;
        rst_n_i  = 1'b1;
        tx_delay = 2;
        p0 = n_pop;
        step();
        n_checks++;
        if (n_pop - p0 != 1) begin
            n_fail++;
            $display("FAIL arst_first_grant: got %0d pops, required 1", n_pop - p0);
        end
        drain("arst", 50);
        n_checks++;
        if (n_cdone != c0 || n_tmo != t0) begin
            n_fail++;
            $display("FAIL arst_no_pulse: got done=%0d timeout=%0d, required 0 and 0",
                     n_cdone - c0, n_tmo - t0);
        end
    endtask

    initial begin
        rst_n_i         = 1'b0;
        ctrl_req_i      = 1'b0;
        ctrl_data_i     = 8'h00;
        cfg_lock_i      = 1'b0;
        tx_fifo_empty_i = 1'b1;
        tx_fifo_data_i  = 8'h00;
        tx_done_i       = 1'b0;
        test_reset();
        test_data_only();
        test_ctrl_priority();
        test_burst();
        test_cfg_lock();
        test_watchdog();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
